// File: rtl/sevenseg_capture_if.sv
// ---------------------------------------------------------------------------
// sevenseg_capture_if
// Scanned seven-segment bus as seen on the display pins.
//   seg_in : 7 segments, active low, bit0=a ... bit6=g
//   an_in  : N digit selects, active low, one-hot while a digit is lit
// master : the side driving the scan (display driver or testbench)
// slave  : the side sampling the scan (sevenseg_capture)
// ---------------------------------------------------------------------------
interface sevenseg_capture_if #(
    parameter int N = 2
);
    logic [6:0]   seg_in;
    logic [N-1:0] an_in;

    modport master (output seg_in, output an_in);
    modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/sevenseg_capture.sv
// ---------------------------------------------------------------------------
// sevenseg_capture
// Samples a multiplexed seven-segment scan and rebuilds a stable per-digit
// segment image. A digit is committed once its (select, segments) pair has
// been seen for STABLE_CYCLES consecutive samples; each commit pulses upd,
// records the digit index and decodes the pattern back to a hex nibble.
// Runs with more than one select asserted are counted in err_cnt.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous reset, active low
//   clr          synchronous clear of all captured state
//   scan         scanned bus (seg_in, an_in), slave side
//   digit_values captured active-low segment pattern per digit
//   hex_values   decoded nibble per digit (0 when not decodable)
//   hex_valid    pattern matched the hex table
//   seen         digit committed at least once since reset/clr
//   upd          one-cycle pulse per digit commit
//   upd_index    index of the last committed digit
//   err_cnt      saturating count of illegal scan runs
// ---------------------------------------------------------------------------
module sevenseg_capture #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 2,
    localparam int IDX_W        = $clog2(N),
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    sevenseg_capture_if.slave  scan,
    output logic [6:0]         digit_values [0:N-1],
    output logic [3:0]         hex_values   [0:N-1],
    output logic [N-1:0]       hex_valid,
    output logic [N-1:0]       seen,
    output logic               upd,
    output logic [IDX_W-1:0]   upd_index,
    output logic [7:0]         err_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

    logic [6:0]       s_seg_q,   s_seg_d;
    logic [N-1:0]     s_an_q,    s_an_d;
    logic [6:0]       prev_seg_q, prev_seg_d;
    logic [N-1:0]     prev_an_q,  prev_an_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    logic [6:0]       digit_values_q [0:N-1];
    logic [6:0]       digit_values_d [0:N-1];
    logic [3:0]       hex_values_q   [0:N-1];
    logic [3:0]       hex_values_d   [0:N-1];
    logic [N-1:0]     hex_valid_q, hex_valid_d;
    logic [N-1:0]     seen_q,      seen_d;
    logic             upd_q,       upd_d;
    logic [IDX_W-1:0] upd_index_q, upd_index_d;
    logic [7:0]       err_cnt_q,   err_cnt_d;

    logic             restart;
    logic             commit;
    logic [IDX_W-1:0] sel_idx;
    int unsigned      zeros;
    logic [4:0]       dec;

    // Active-low pattern to {valid, nibble}; unknown patterns decode to 0.
    function automatic logic [4:0] decode_hex(input logic [6:0] pat);
        case (pat)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    // Next-state logic. A run counter value of 0 means "no previous sample",
    // so the first sample after reset/clr always starts a fresh run. A
    // commit fires on the edge the counter reaches STABLE_CYCLES, either by
    // counting up or by a restart when STABLE_CYCLES is 1; once saturated
    // the run never commits again.
    always_comb begin
        s_seg_d        = scan.seg_in;
        s_an_d         = scan.an_in;
        prev_seg_d     = s_seg_q;
        prev_an_d      = s_an_q;
        digit_values_d = digit_values_q;
        hex_values_d   = hex_values_q;
        hex_valid_d    = hex_valid_q;
        seen_d         = seen_q;
        upd_d          = 1'b0;
        upd_index_d    = upd_index_q;
        err_cnt_d      = err_cnt_q;
        zeros          = 0;
        sel_idx        = '0;
        dec            = decode_hex(s_seg_q);

        for (int i = 0; i < N; i++) begin
            if (!s_an_q[i]) begin
                zeros   = zeros + 1;
                sel_idx = IDX_W'(i);
            end
        end

        restart = (run_cnt_q == '0) ||
                  (s_an_q != prev_an_q) || (s_seg_q != prev_seg_q);

        if (restart) begin
            run_cnt_d = CNT_W'(1);
        end else if (run_cnt_q == CNT_SAT) begin
            run_cnt_d = CNT_SAT;
        end else begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end

        commit = (run_cnt_d == CNT_SAT) && (restart || (run_cnt_q != CNT_SAT));

        if (commit && (zeros == 1)) begin
            digit_values_d[sel_idx] = s_seg_q;
            hex_values_d[sel_idx]   = dec[3:0];
            hex_valid_d[sel_idx]    = dec[4];
            seen_d[sel_idx]         = 1'b1;
            upd_d                   = 1'b1;
            upd_index_d             = sel_idx;
        end else if (commit && (zeros >= 2) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        // clr wins over any commit on the same edge; only sampling survives.
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                digit_values_d[i] = 7'h7F;
                hex_values_d[i]   = 4'h0;
            end
            hex_valid_d = '0;
            seen_d      = '0;
            upd_d       = 1'b0;
            upd_index_d = '0;
            err_cnt_d   = 8'd0;
            run_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_seg_q    <= 7'h7F;
            s_an_q     <= '1;
            prev_seg_q <= 7'h7F;
            prev_an_q  <= '1;
            run_cnt_q  <= '0;
            for (int i = 0; i < N; i++) begin
                digit_values_q[i] <= 7'h7F;
                hex_values_q[i]   <= 4'h0;
            end
            hex_valid_q <= '0;
            seen_q      <= '0;
            upd_q       <= 1'b0;
            upd_index_q <= '0;
            err_cnt_q   <= 8'd0;
        end else begin
            s_seg_q        <= s_seg_d;
            s_an_q         <= s_an_d;
            prev_seg_q     <= prev_seg_d;
            prev_an_q      <= prev_an_d;
            run_cnt_q      <= run_cnt_d;
            digit_values_q <= digit_values_d;
            hex_values_q   <= hex_values_d;
            hex_valid_q    <= hex_valid_d;
            seen_q         <= seen_d;
            upd_q          <= upd_d;
            upd_index_q    <= upd_index_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign digit_values = digit_values_q;
    assign hex_values   = hex_values_q;
    assign hex_valid    = hex_valid_q;
    assign seen         = seen_q;
    assign upd          = upd_q;
    assign upd_index    = upd_index_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_capture
// Self-checking bench for sevenseg_capture (N=4, STABLE_CYCLES=2). The
// reference model keeps a short history of the sampled (select, segments)
// pairs since the last reset/clr and commits when the newest STABLE_CYCLES
// entries are identical and form the start of a run.
// ---------------------------------------------------------------------------
module tb_sevenseg_capture;

    localparam int N = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic clr;

    logic [6:0] digit_values [0:N-1];
    logic [3:0] hex_values   [0:N-1];
    logic [N-1:0] hex_valid;
    logic [N-1:0] seen;
    logic         upd;
    logic [1:0]   upd_index;
    logic [7:0]   err_cnt;

    sevenseg_capture_if #(.N(N)) scan_if ();

    sevenseg_capture #(.N(N), .STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .scan         (scan_if),
        .digit_values (digit_values),
        .hex_values   (hex_values),
        .hex_valid    (hex_valid),
        .seen         (seen),
        .upd          (upd),
        .upd_index    (upd_index),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0]  m_s_seg;
    logic [3:0]  m_s_an;
    logic [10:0] hist [$];
    logic [6:0]  e_digit [N];
    logic [3:0]  e_hex   [N];
    logic [N-1:0] e_valid;
    logic [N-1:0] e_seen;
    logic        e_upd;
    logic [1:0]  e_idx;
    int          e_err;

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else
            passed++;
    endtask

    function automatic int lookupHex(input logic [6:0] pat);
        for (int k = 0; k < 16; k++)
            if (hex_tab[k] == pat) return k;
        return -1;
    endfunction

    task automatic modelClearOutputs();
        for (int k = 0; k < N; k++) begin
            e_digit[k] = 7'h7F;
            e_hex[k]   = 4'h0;
        end
        e_valid = '0;
        e_seen  = '0;
        e_upd   = 1'b0;
        e_idx   = '0;
        e_err   = 0;
        hist.delete();
    endtask

    task automatic modelReset();
        modelClearOutputs();
        m_s_seg = 7'h7F;
        m_s_an  = 4'hF;
    endtask

    // One clock edge of the reference: judge the currently held sample,
    // then take the newly driven inputs as the next sample.
    task automatic modelEdge(input logic clr_v, input logic [3:0] an, input logic [6:0] seg);
        logic [10:0] v;
        logic        commit;
        int          sz;
        int          h;
        v     = {m_s_an, m_s_seg};
        e_upd = 1'b0;
        if (clr_v) begin
            modelClearOutputs();
        end else begin
            hist.push_back(v);
            if (hist.size() > S + 1) void'(hist.pop_front());
            sz     = hist.size();
            commit = (sz >= S);
            for (int k = 0; k < S && k < sz; k++)
                if (hist[sz-1-k] != v) commit = 1'b0;
            if (commit && sz > S && hist[sz-S-1] == v) commit = 1'b0;
            if (commit && $countones(~m_s_an) == 1) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_s_an[k]) begin
                        h          = lookupHex(m_s_seg);
                        e_digit[k] = m_s_seg;
                        e_valid[k] = (h >= 0);
                        e_hex[k]   = (h >= 0) ? 4'(h) : 4'h0;
                        e_seen[k]  = 1'b1;
                        e_upd      = 1'b1;
                        e_idx      = 2'(k);
                    end
                end
            end else if (commit && $countones(~m_s_an) >= 2) begin
                if (e_err < 255) e_err++;
            end
        end
        m_s_an  = an;
        m_s_seg = seg;
    endtask

    task automatic checkAll();
        checkOutput("upd",       64'(upd),       64'(e_upd));
        checkOutput("upd_index", 64'(upd_index), 64'(e_idx));
        checkOutput("err_cnt",   64'(err_cnt),   64'(e_err));
        checkOutput("seen",      64'(seen),      64'(e_seen));
        checkOutput("hex_valid", 64'(hex_valid), 64'(e_valid));
        checkOutput("digit_values",
                    64'({digit_values[0], digit_values[1], digit_values[2], digit_values[3]}),
                    64'({e_digit[0], e_digit[1], e_digit[2], e_digit[3]}));
        checkOutput("hex_values",
                    64'({hex_values[0], hex_values[1], hex_values[2], hex_values[3]}),
                    64'({e_hex[0], e_hex[1], e_hex[2], e_hex[3]}));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, check #1 later.
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input logic clr_v);
        scan_if.an_in  = an;
        scan_if.seg_in = seg;
        clr            = clr_v;
        @(posedge clk);
        modelEdge(clr_v, an, seg);
        #1;
        checkAll();
    endtask

    task automatic holdPair(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(an, seg, 1'b0);
    endtask

    int upd_count;

    initial begin
        reset_n        = 1'b0;
        clr            = 1'b0;
        scan_if.an_in  = 4'hF;
        scan_if.seg_in = 7'h7F;
        modelReset();
        #12;
        checkAll();
        checkOutput("reset_digit0", 64'(digit_values[0]), 64'h7F);
        reset_n = 1'b1;
        #5;

        // Single digit 1 showing '2'
        holdPair(4'b1101, 7'h24, 3);
        holdPair(4'b1111, 7'h7F, 2);
        checkOutput("t1_digit1", 64'(digit_values[1]), 64'h24);
        checkOutput("t1_hex1",   64'(hex_values[1]),   64'h2);
        checkOutput("t1_seen",   64'(seen),            64'b0010);

        // Round-robin scan, twice
        upd_count = 0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < N; d++) begin
                logic [6:0] pats [4] = '{7'h40, 7'h79, 7'h30, 7'h0E};
                for (int c = 0; c < 4; c++) begin
                    applyStimulus(~(4'b1 << d), pats[d], 1'b0);
                    if (upd) upd_count++;
                end
            end
        end
        holdPair(4'hF, 7'h7F, 2);
        checkOutput("t2_upd_count", 64'(upd_count), 64'd8);
        checkOutput("t2_hex",
                    64'({hex_values[0], hex_values[1], hex_values[2], hex_values[3]}), 64'h013F);
        checkOutput("t2_valid", 64'(hex_valid), 64'hF);

        // Glitch then digit 3, then a long blank stretch
        applyStimulus(4'b1110, 7'h12, 1'b0);
        holdPair(4'b0111, 7'h19, 3);
        holdPair(4'hF, 7'h7F, 10);

        // Undecodable pattern on digit 2
        holdPair(4'b1011, 7'h7E, 3);
        holdPair(4'hF, 7'h7F, 1);
        checkOutput("t5_valid2", 64'(hex_valid[2]), 64'd0);
        checkOutput("t5_digit2", 64'(digit_values[2]), 64'h7E);

        // Randomized runs with occasional clr
        for (int r = 0; r < 200; r++) begin
            int         kind = $urandom_range(0, 9);
            int         hold = $urandom_range(1, 4);
            logic [3:0] an;
            logic [6:0] seg;
            if (kind <= 5) begin
                an = ~(4'b1 << $urandom_range(0, 3));
            end else if (kind <= 7) begin
                an = 4'hF;
            end else begin
                int a = $urandom_range(0, 3);
                int b = (a + $urandom_range(1, 3)) % 4;
                an = 4'($urandom) & ~(4'b1 << a) & ~(4'b1 << b);
            end
            seg = ($urandom_range(0, 1) == 0) ? hex_tab[$urandom_range(0, 15)] : 7'($urandom);
            for (int c = 0; c < hold; c++)
                applyStimulus(an, seg, ($urandom_range(0, 29) == 0));
        end

        // Illegal-run saturation
        for (int r = 0; r < 300; r++) begin
            holdPair(4'b1100, 7'h24, 5);
            applyStimulus(4'hF, 7'h7F, 1'b0);
        end
        checkOutput("t4_err_sat", 64'(err_cnt), 64'd255);

        // clr coincident with a pending commit
        holdPair(4'b1110, 7'h79, 2);
        applyStimulus(4'b1110, 7'h79, 1'b1);
        checkOutput("t6_clr_upd", 64'(upd), 64'd0);
        checkOutput("t6_clr_err", 64'(err_cnt), 64'd0);
        holdPair(4'b1110, 7'h79, 3);

        // Asynchronous reset in the middle of a run
        applyStimulus(4'b1011, 7'h30, 1'b0);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        #3;
        reset_n = 1'b1;
        holdPair(4'b1011, 7'h30, 3);
        holdPair(4'hF, 7'h7F, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
